// File: rtl/spi_apb_mst_pkg.sv
// Shared types and constants for the SPI APB master bridge.
//   apb_mst_state_e : bridge FSM state encoding
//   SPI_REG_*       : byte offsets of the SPI master register slave, for
//                     sequencers and benches that build request streams
package spi_apb_mst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_mst_state_e;

  localparam logic [7:0] SPI_REG_STATUS = 8'h00;
  localparam logic [7:0] SPI_REG_CLKDIV = 8'h04;
  localparam logic [7:0] SPI_REG_SPICMD = 8'h08;
  localparam logic [7:0] SPI_REG_SPIADR = 8'h0C;
  localparam logic [7:0] SPI_REG_SPILEN = 8'h10;
  localparam logic [7:0] SPI_REG_SPIDUM = 8'h14;
  localparam logic [7:0] SPI_REG_TXFIFO = 8'h18;
  localparam logic [7:0] SPI_REG_RSVD1C = 8'h1C;
  localparam logic [7:0] SPI_REG_RXFIFO = 8'h20;
  localparam logic [7:0] SPI_REG_INTCFG = 8'h24;

endpackage

// File: rtl/spi_apb_master_bridge.sv
// APB initiator: converts a valid/ready request stream into APB SETUP/ACCESS
// transfers towards the SPI master register slave and returns read data and
// error status on a valid/ready response stream.
//
// Optional feature macro: SPI_APB_MST_TIMEOUT_EN
//   defined   : ACCESS is aborted after TIMEOUT_CYCLES cycles with PREADY=0
//   undefined : ACCESS waits indefinitely, rsp_timeout_o tied 0
//
// Ports
//   HCLK, HRESET          clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake; req_write_i/addr_i/wdata_i payload
//   rsp_valid_o/ready_i   response handshake; rsp_rdata_o/err_o/timeout_o payload
//   busy_o                FSM not idle
//   PADDR..PENABLE        APB request side (outputs)
//   PRDATA/PREADY/PSLVERR APB completion side (inputs)
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | ready for a request
// ST_SETUP  | APB setup phase, PSEL=1 PENABLE=0, one cycle
// ST_ACCESS | APB access phase, PSEL=1 PENABLE=1, until PREADY
// ST_RESP   | response held on rsp_* until rsp_ready_i
module spi_apb_master_bridge
  import spi_apb_mst_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic                      busy_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  apb_mst_state_e state, state_nxt;
  logic accept;
  logic xfer_done;
  logic tmo_hit;

  // A limit of zero could never be reached by the counter below.
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_cfg_invalid
  end

  assign accept    = req_valid_i && req_ready_o;
  assign xfer_done = (state == ST_ACCESS) && PREADY;

`ifdef SPI_APB_MST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // PREADY on the limit cycle wins, so the abort requires PREADY=0.
  assign tmo_hit = (state == ST_ACCESS) && !PREADY &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tmo_cnt       <= '0;
      rsp_timeout_o <= 1'b0;
    end else begin
      if (accept) begin
        tmo_cnt <= '0;
      end else if ((state == ST_ACCESS) && !PREADY && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (xfer_done) begin
        rsp_timeout_o <= 1'b0;
      end else if (tmo_hit) begin
        rsp_timeout_o <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit       = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (xfer_done || tmo_hit) state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready_i) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // All decoded from the state register; only req_ready_o also sees HRESET so
  // that nothing is offered or accepted while reset is held.
  always_comb begin
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = (state != ST_IDLE);
    case (state)
      ST_IDLE:   req_ready_o = !HRESET;
      ST_SETUP:  PSEL = 1'b1;
      ST_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      ST_RESP:   rsp_valid_o = 1'b1;
      default:   ;
    endcase
  end

  // APB request fields change only on accept, so they hold across the whole
  // transfer and in IDLE/RESP. Response fields change only on completion.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (accept) begin
        PADDR  <= req_addr_i & ~APB_ADDR_WIDTH'(3);
        PWDATA <= req_wdata_i;
        PWRITE <= req_write_i;
      end
      if (xfer_done) begin
        rsp_rdata_o <= (PWRITE || PSLVERR) ? 32'h0 : PRDATA;
        rsp_err_o   <= PSLVERR;
      end else if (tmo_hit) begin
        rsp_rdata_o <= 32'h0;
        rsp_err_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_apb_master_bridge.sv
module tb_spi_apb_master_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_timeout_o, busy_o;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 HCLK = ~HCLK;

  spi_apb_master_bridge #(.APB_ADDR_WIDTH(32), .TIMEOUT_CYCLES(256)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          waits;
    int          stall;
    logic [31:0] exp_paddr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic bad_acc;
    logic bad_stall;
    req_valid_i = 1'b1;
    req_write_i = v.wr;
    req_addr_i  = v.addr;
    req_wdata_i = v.wdata;
    #1;
    check("idle_req_ready", 32'(req_ready_o), 32'd1);
    check("idle_busy", 32'(busy_o), 32'd0);
    tick();
    // request inputs must be ignored from here on
    req_valid_i = 1'b0;
    req_write_i = ~v.wr;
    req_addr_i  = 32'hFFFF_FFF0;
    req_wdata_i = 32'h0BAD_0BAD;
    #1;
    check("setup_psel_penable", 32'({PSEL, PENABLE}), 32'b10);
    check("setup_paddr", PADDR, v.exp_paddr);
    check("setup_pwrite", 32'(PWRITE), 32'(v.wr));
    if (v.wr) check("setup_pwdata", PWDATA, v.wdata);
    check("setup_req_ready", 32'(req_ready_o), 32'd0);
    tick();
    bad_acc = 1'b0;
    for (int k = 0; k <= v.waits; k++) begin
      if (!(PSEL && PENABLE) || rsp_valid_o || PADDR !== v.exp_paddr ||
          PWRITE !== v.wr || (v.wr && PWDATA !== v.wdata)) bad_acc = 1'b1;
      PREADY  = (k == v.waits);
      PSLVERR = (k == v.waits) ? v.slverr : 1'b0;
      PRDATA  = (k == v.waits) ? v.prdata : 32'h5555_AAAA;
      tick();
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h7777_7777;
    #1;
    check("access_shape", 32'(bad_acc), 32'd0);
    check("resp_psel_penable", 32'({PSEL, PENABLE}), 32'b00);
    check("resp_valid", 32'(rsp_valid_o), 32'd1);
    check("resp_rdata", rsp_rdata_o, v.exp_rdata);
    check("resp_err", 32'(rsp_err_o), 32'(v.exp_err));
    check("resp_timeout", 32'(rsp_timeout_o), 32'd0);
    check("resp_req_ready", 32'(req_ready_o), 32'd0);
    bad_stall = 1'b0;
    for (int s = 0; s < v.stall; s++) begin
      req_valid_i = 1'b1;
      tick();
      if (!rsp_valid_o || req_ready_o || rsp_rdata_o !== v.exp_rdata ||
          rsp_err_o !== v.exp_err || PADDR !== v.exp_paddr) bad_stall = 1'b1;
    end
    req_valid_i = 1'b0;
    if (v.stall > 0) check("resp_stable_stall", 32'(bad_stall), 32'd0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    #1;
    check("after_hs_valid", 32'(rsp_valid_o), 32'd0);
    check("after_hs_req_ready", 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    int   n;
    vecs[0] = '{1'b1, 32'h04, 32'h0000_0003, 32'h1111_1111, 1'b0, 0, 0, 32'h04, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 1, 32'h20, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h18, 32'hA5A5_0001, 32'h2222_2222, 1'b1, 1, 0, 32'h18, 32'h0, 1'b1};
    vecs[3] = '{1'b0, 32'h10, 32'h0,         32'h1234_5678, 1'b1, 0, 0, 32'h10, 32'h0, 1'b1};
    vecs[4] = '{1'b0, 32'h0B, 32'h0,         32'hCAFE_F00D, 1'b0, 0, 2, 32'h08, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{1'b1, 32'h24, 32'hFFFF_FFFF, 32'h3333_3333, 1'b0, 2, 0, 32'h24, 32'h0, 1'b0};

    HRESET = 1'b1;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    rsp_ready_i = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); tick();
    check("rst_outputs", 32'({req_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o,
                              busy_o, PWRITE, PSEL, PENABLE}), 32'd0);
    check("rst_paddr", PADDR, 32'd0);
    check("rst_rdata", rsp_rdata_o | PWDATA, 32'd0);
    HRESET = 1'b0;
    #1;
    check("rst_release_ready", 32'(req_ready_o), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Back-to-back requests with a 5-cycle response stall.
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h08; req_wdata_i = 32'h0000_00A1;
    tick();
    req_addr_i = 32'h0C; req_wdata_i = 32'h0000_00B2;
    tick();
    PREADY = 1'b1;
    tick();
    PREADY = 1'b0;
    bad = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      if (req_ready_o || !rsp_valid_o || PSEL || PADDR !== 32'h08) bad = 1'b1;
      tick();
    end
    check("b2b_stall_blocked", 32'(bad), 32'd0);
    rsp_ready_i = 1'b1;
    #1;
    check("b2b_hs_cycle_ready", 32'(req_ready_o), 32'd0);
    tick();
    rsp_ready_i = 1'b0;
    #1;
    check("b2b_idle_ready", 32'(req_ready_o), 32'd1);
    check("b2b_idle_paddr_held", PADDR, 32'h08);
    check("b2b_idle_psel", 32'(PSEL), 32'd0);
    tick();
    req_valid_i = 1'b0;
    #1;
    check("b2b_setup2_psel_penable", 32'({PSEL, PENABLE}), 32'b10);
    check("b2b_setup2_paddr", PADDR, 32'h0C);
    check("b2b_setup2_pwdata", PWDATA, 32'h0000_00B2);
    tick();
    PREADY = 1'b1;
    tick();
    PREADY = 1'b0;
    check("b2b_resp2_valid", 32'(rsp_valid_o), 32'd1);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // Reset asserted in the ACCESS phase of a read.
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h00;
    tick();
    req_valid_i = 1'b0;
    tick();
    tick();
    check("rstmid_in_access", 32'({PSEL, PENABLE}), 32'b11);
    HRESET = 1'b1; PREADY = 1'b1; PRDATA = 32'h9999_9999;
    tick();
    check("rstmid_outputs", 32'({req_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o,
                                 busy_o, PWRITE, PSEL, PENABLE}), 32'd0);
    check("rstmid_data", rsp_rdata_o | PADDR | PWDATA, 32'd0);
    HRESET = 1'b0; PREADY = 1'b0;
    bad = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      if (rsp_valid_o || PSEL || busy_o) bad = 1'b1;
      tick();
    end
    check("rstmid_no_rsp", 32'(bad), 32'd0);

`ifdef SPI_APB_MST_TIMEOUT_EN
    // PREADY held low: abort after 256 ACCESS cycles.
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h14;
    tick();
    req_valid_i = 1'b0;
    tick();
    PRDATA = 32'h4444_4444;
    n = 0;
    while (!rsp_valid_o && n < 400) begin
      tick();
      n++;
    end
    check("tmo_access_cycles", 32'(n), 32'd256);
    check("tmo_err", 32'(rsp_err_o), 32'd1);
    check("tmo_flag", 32'(rsp_timeout_o), 32'd1);
    check("tmo_rdata", rsp_rdata_o, 32'd0);
    check("tmo_psel", 32'(PSEL), 32'd0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // PREADY on the limit cycle completes normally.
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h20;
    tick();
    req_valid_i = 1'b0;
    tick();
    for (int k = 0; k < 255; k++) tick();
    check("tmo_edge_in_access", 32'({PSEL, PENABLE, rsp_valid_o}), 32'b110);
    PREADY = 1'b1; PRDATA = 32'h600D_0256;
    tick();
    PREADY = 1'b0;
    check("tmo_edge_valid", 32'(rsp_valid_o), 32'd1);
    check("tmo_edge_err", 32'(rsp_err_o), 32'd0);
    check("tmo_edge_flag", 32'(rsp_timeout_o), 32'd0);
    check("tmo_edge_rdata", rsp_rdata_o, 32'h600D_0256);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
`else
    // Without the timeout, ACCESS waits for as long as PREADY stays low.
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h14;
    tick();
    req_valid_i = 1'b0;
    tick();
    bad = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (!(PSEL && PENABLE) || rsp_valid_o) bad = 1'b1;
      tick();
    end
    check("notmo_still_access", 32'(bad), 32'd0);
    check("notmo_access_1000", 32'({PSEL, PENABLE}), 32'b11);
    PREADY = 1'b1; PRDATA = 32'h0000_0A5A;
    tick();
    PREADY = 1'b0;
    check("notmo_valid", 32'(rsp_valid_o), 32'd1);
    check("notmo_timeout_tied", 32'(rsp_timeout_o), 32'd0);
    check("notmo_rdata", rsp_rdata_o, 32'h0000_0A5A);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
`endif

    #1;
    check("final_idle", 32'({busy_o, req_ready_o}), 32'b01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
